// File: rtl/rr_arbiter_4to2.sv
// rtl/rr_arbiter_4to2.sv - four-requester round-robin arbiter with registered one-hot and encoded grant
//
// Optional feature macro: RR_ARBITER_HOLD_TIMEOUT_EN
//   defined   : an owner that has held the grant for MAX_HOLD cycles while another
//               requester waits is forced to rotate.
//   undefined : the owner keeps the grant until its request drops.
//
// All outputs are flops; req only reaches them through the next-state logic.

module rr_arbiter_4to2 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

`ifdef RR_ARBITER_HOLD_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    // Last hold-counter value before the owner must yield under contention.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  gnt_idx_q, gnt_idx_d;
    logic        gnt_valid_q, gnt_valid_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  hcnt_q, hcnt_d;

    // Search result among all requesters and among requesters other than the owner.
    logic        win_found;
    logic [1:0]  win_idx;
    logic        alt_found;
    logic [1:0]  alt_idx;
    logic        owner_req;
    logic        others_req;
    logic        hold_expired;

    // First set bit of r, scanning ptr, ptr+1, ptr+2, ptr+3 with 2-bit wrap.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int i = 0; i < 4; i++) begin
            cand = p + 2'(i);
            if (!res[2] && r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    // Arbitration candidates and hold/timeout conditions for the coming edge.
    always_comb begin
        {win_found, win_idx} = rr_pick(req, ptr_q);
        {alt_found, alt_idx} = rr_pick(req & ~gnt_q, ptr_q);
        owner_req    = |(req & gnt_q);
        others_req   = |(req & ~gnt_q);
        hold_expired = TIMEOUT_EN && (hcnt_q == HOLD_LAST);
    end

    // Next-state: grant, hold, rotate or release.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        hcnt_d      = hcnt_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = GRANT;
                    gnt_d       = 4'b0001 << win_idx;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    ptr_d       = win_idx + 2'd1;
                    hcnt_d      = 8'd0;
                end
            end

            GRANT: begin
                if (!owner_req) begin
                    // Owner released: hand over in the same edge, no bubble.
                    if (win_found) begin
                        gnt_d       = 4'b0001 << win_idx;
                        gnt_idx_d   = win_idx;
                        gnt_valid_d = 1'b1;
                        ptr_d       = win_idx + 2'd1;
                        hcnt_d      = 8'd0;
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = 4'b0000;
                        gnt_idx_d   = 2'd0;
                        gnt_valid_d = 1'b0;
                    end
                end else if (hold_expired && others_req) begin
                    // Forced rotation: owner is excluded from this search.
                    gnt_d       = 4'b0001 << alt_idx;
                    gnt_idx_d   = alt_idx;
                    gnt_valid_d = 1'b1;
                    ptr_d       = alt_idx + 2'd1;
                    hcnt_d      = 8'd0;
                end else if (hold_expired) begin
                    // Nobody else waiting: owner keeps it and a fresh window starts.
                    hcnt_d = 8'd0;
                end else if (hcnt_q != 8'hFF) begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end

            default: begin
                state_d     = IDLE;
                gnt_d       = 4'b0000;
                gnt_idx_d   = 2'd0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears outputs without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 4'b0000;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= 2'd0;
            hcnt_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
            hcnt_q      <= hcnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_4to2.sv
// tb/tb_rr_arbiter_4to2.sv - scoreboard bench for rr_arbiter_4to2 with a behavioural model

module tb_rr_arbiter_4to2;

    localparam int MAX_HOLD = 4;

`ifdef RR_ARBITER_HOLD_TIMEOUT_EN
    localparam bit MODEL_TIMEOUT = 1'b1;
`else
    localparam bit MODEL_TIMEOUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    rr_arbiter_4to2 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [6:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Behavioural model: who owns the resource, whose turn is next, how long held.
    int m_owner;
    int m_next;
    int m_tenure;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got gnt=%b idx=%0d valid=%b expected gnt=%b idx=%0d valid=%b",
                     name, cyc, act[6:3], act[2:1], act[0], exp[6:3], exp[2:1], exp[0]);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start, input int excl);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (start + k) % 4;
            if (j != excl && r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [6:0] model_out();
        logic [6:0] o;
        if (m_owner < 0) o = 7'b0;
        else o = {4'(1 << m_owner), 2'(m_owner), 1'b1};
        return o;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_next   = 0;
        m_tenure = 0;
    endtask

    task automatic model_take(input int w);
        m_owner  = w;
        m_next   = (w + 1) % 4;
        m_tenure = 1;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int w;
        if (m_owner < 0 || !r[m_owner]) begin
            w = pick(r, m_next, -1);
            if (w >= 0) model_take(w);
            else m_owner = -1;
        end else if (MODEL_TIMEOUT && m_tenure == MAX_HOLD) begin
            w = pick(r, m_next, m_owner);
            if (w >= 0) model_take(w);
            else m_tenure = 1;
        end else if (m_tenure < 256) begin
            m_tenure++;
        end
    endtask

    // Called just after a rising edge: drive req for the next edge and queue its outcome.
    task automatic step(input logic [3:0] r);
        sb_item_t it;
        req = r;
        model_edge(r);
        it.cyc = cyc + 1;
        it.exp = model_out();
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge: pulse rst between edges, then resume with r_after.
    task automatic do_reset(input logic [3:0] r_after);
        #6;
        rst = 1'b1;
        #1;
        check("async_clear", {gnt, gnt_idx, gnt_valid}, 7'b0);
        model_reset();
        #1;
        rst = 1'b0;
        step(r_after);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare each registered output against the scoreboard entry for this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            sb_item_t it;
            it = sb.pop_front();
            if (it.cyc < cyc) check("missed_cycle", 7'h7F, it.exp);
            else check("grant", {gnt, gnt_idx, gnt_valid}, it.exp);
        end
    end

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_state", {gnt, gnt_idx, gnt_valid}, 7'b0);
        rst = 1'b0;

        // Idle with no requests.
        repeat (5) step(4'b0000);

        // Single request then release.
        step(4'b0100);
        step(4'b0000);
        step(4'b0000);

        // Fairness: all request, each owner drops for one cycle after its grant.
        do_reset(4'b1111);
        for (int i = 0; i < 8; i++) step(4'b1111 & ~4'(1 << m_owner));

        // Wrap: requester 3 wins, then releases while 0 is requesting.
        do_reset(4'b1000);
        step(4'b1001);
        step(4'b0001);
        step(4'b0000);

        // Contention between 0 and 1 held continuously.
        step(4'b0011);
        repeat (18) step(4'b0011);
        // Lone owner past the hold limit.
        repeat (10) step(4'b0001);
        step(4'b0000);

        // Reset in the middle of a grant to requester 2.
        step(4'b0100);
        step(4'b0100);
        do_reset(4'b1111);
        step(4'b1111);
        step(4'b0000);

        // Randomised traffic with persistence and occasional owner release.
        begin
            logic [3:0] r;
            r = 4'b0000;
            for (int i = 0; i < 400; i++) begin
                int sel;
                sel = $urandom_range(0, 9);
                if (sel < 3) r = 4'($urandom_range(0, 15));
                else if (sel < 5 && m_owner >= 0) r = r & ~4'(1 << m_owner);
                else if (sel < 6) r = r | 4'(1 << $urandom_range(0, 3));
                step(r);
            end
        end

        step(4'b0000);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
